// File: rtl/decode_stage.sv
// Registered instruction-decode stage for the RV32/RV64 core: valid/ready handshake,
// flush, illegal-instruction detection and a saturating count of accepted instructions.
package decode_stage_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_t;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
endpackage

module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [XLEN-1:0]  pc_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  pc_o,
  output logic [4:0]       rs1_addr_o,
  output logic [4:0]       rs2_addr_o,
  output logic [4:0]       rd_addr_o,
  output alu_op_t          alu_op_o,
  output logic             alu_src_o,
  output logic             reg_write_o,
  output logic [XLEN-1:0]  imm_o,
  output logic             word_op_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic [2:0]       mem_size_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] instr_cnt_o
);
  localparam bit RV64    = (XLEN == 64);
  localparam int SHAMT_W = RV64 ? 6 : 5;
  localparam int HI_W    = 12 - SHAMT_W;
  // Shift-immediate bits above shamt; SRAI sets only instr[30].
  localparam logic [HI_W-1:0] SRAI_HI = {2'b01, {(HI_W-2){1'b0}}};

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic [HI_W-1:0]    shift_hi;
  logic signed [11:0] imm_i12;
  logic signed [11:0] imm_s12;
  logic signed [31:0] imm_u32;
  logic               funct7_ok;
  logic               accept;

  assign opcode    = instr_i[6:0];
  assign funct3    = instr_i[14:12];
  assign funct7    = instr_i[31:25];
  assign shift_hi  = instr_i[31:20+SHAMT_W];
  assign imm_i12   = instr_i[31:20];
  assign imm_s12   = {instr_i[31:25], instr_i[11:7]};
  assign imm_u32   = {instr_i[31:12], 12'h000};
  assign funct7_ok = (funct7 == 7'b0000000) ||
                     (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));

  assign in_ready_o = !rst_i && (!out_valid_o || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  alu_op_t         d_alu_op;
  logic            d_alu_src, d_reg_write, d_word_op, d_mem_read, d_mem_write, d_illegal;
  logic [2:0]      d_mem_size;
  logic [4:0]      d_rs1;
  logic [XLEN-1:0] d_imm;

  always_comb begin
    // NOTE: every decode output takes a default first, so no path through the case infers a latch.
    d_alu_op    = ALU_ADD;
    d_alu_src   = 1'b0;
    d_reg_write = 1'b0;
    d_word_op   = 1'b0;
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    d_mem_size  = 3'b000;
    d_illegal   = 1'b0;
    d_imm       = '0;
    d_rs1       = instr_i[19:15];

    case (opcode)
      OPC_OP_IMM: begin
        d_alu_src   = 1'b1;
        d_reg_write = 1'b1;
        d_imm       = XLEN'(imm_i12);
        case (funct3)
          3'b001: begin
            d_alu_op  = ALU_SLL;
            d_illegal = (shift_hi != '0);
          end
          3'b010: d_alu_op = ALU_SLT;
          3'b011: d_alu_op = ALU_SLTU;
          3'b100: d_alu_op = ALU_XOR;
          3'b101: begin
            d_alu_op  = instr_i[30] ? ALU_SRA : ALU_SRL;
            d_illegal = (shift_hi != '0) && (shift_hi != SRAI_HI);
          end
          3'b110: d_alu_op = ALU_OR;
          3'b111: d_alu_op = ALU_AND;
          default: d_alu_op = ALU_ADD;
        endcase
      end
      OPC_OP: begin
        d_reg_write = 1'b1;
        d_illegal   = !funct7_ok;
        case (funct3)
          3'b000: d_alu_op = instr_i[30] ? ALU_SUB : ALU_ADD;
          3'b001: d_alu_op = ALU_SLL;
          3'b010: d_alu_op = ALU_SLT;
          3'b011: d_alu_op = ALU_SLTU;
          3'b100: d_alu_op = ALU_XOR;
          3'b101: d_alu_op = instr_i[30] ? ALU_SRA : ALU_SRL;
          3'b110: d_alu_op = ALU_OR;
          default: d_alu_op = ALU_AND;
        endcase
      end
      OPC_LOAD: begin
        d_mem_read  = 1'b1;
        d_reg_write = 1'b1;
        d_alu_src   = 1'b1;
        d_mem_size  = funct3;
        d_imm       = XLEN'(imm_i12);
        d_illegal   = (funct3 == 3'b111) ||
                      (!RV64 && (funct3 == 3'b011 || funct3 == 3'b110));
      end
      OPC_STORE: begin
        d_mem_write = 1'b1;
        d_alu_src   = 1'b1;
        d_mem_size  = funct3;
        d_imm       = XLEN'(imm_s12);
        d_illegal   = funct3[2] || (!RV64 && funct3 == 3'b011);
      end
      OPC_LUI: begin
        d_reg_write = 1'b1;
        d_alu_src   = 1'b1;
        d_imm       = XLEN'(imm_u32);
        d_rs1       = 5'd0;
      end
      OPC_OP_IMM_32: begin
        if (RV64) begin
          d_word_op   = 1'b1;
          d_reg_write = 1'b1;
          d_alu_src   = 1'b1;
          d_imm       = XLEN'(imm_i12);
          case (funct3)
            3'b000: d_alu_op = ALU_ADD;
            3'b001: begin
              d_alu_op  = ALU_SLL;
              d_illegal = (funct7 != 7'b0000000);
            end
            3'b101: begin
              d_alu_op  = instr_i[30] ? ALU_SRA : ALU_SRL;
              d_illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
            end
            default: d_illegal = 1'b1;
          endcase
        end else begin
          d_illegal = 1'b1;
        end
      end
      OPC_OP_32: begin
        if (RV64) begin
          d_word_op   = 1'b1;
          d_reg_write = 1'b1;
          d_illegal   = !funct7_ok;
          case (funct3)
            3'b000: d_alu_op = instr_i[30] ? ALU_SUB : ALU_ADD;
            3'b001: d_alu_op = ALU_SLL;
            3'b101: d_alu_op = instr_i[30] ? ALU_SRA : ALU_SRL;
            default: d_illegal = 1'b1;
          endcase
        end else begin
          d_illegal = 1'b1;
        end
      end
      default: d_illegal = 1'b1;
    endcase

    // An illegal bundle still flows downstream but must not touch state.
    if (d_illegal) begin
      d_reg_write = 1'b0;
      d_mem_read  = 1'b0;
      d_mem_write = 1'b0;
    end
    if (instr_i[11:7] == 5'd0) d_reg_write = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      out_valid_o <= 1'b0;
      pc_o        <= '0;
      rs1_addr_o  <= '0;
      rs2_addr_o  <= '0;
      rd_addr_o   <= '0;
      alu_op_o    <= ALU_ADD;
      alu_src_o   <= 1'b0;
      reg_write_o <= 1'b0;
      imm_o       <= '0;
      word_op_o   <= 1'b0;
      mem_read_o  <= 1'b0;
      mem_write_o <= 1'b0;
      mem_size_o  <= '0;
      illegal_o   <= 1'b0;
      instr_cnt_o <= '0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (accept) begin
      out_valid_o <= 1'b1;
      pc_o        <= pc_i;
      rs1_addr_o  <= d_rs1;
      rs2_addr_o  <= instr_i[24:20];
      rd_addr_o   <= instr_i[11:7];
      alu_op_o    <= d_alu_op;
      alu_src_o   <= d_alu_src;
      reg_write_o <= d_reg_write;
      imm_o       <= d_imm;
      word_op_o   <= d_word_op;
      mem_read_o  <= d_mem_read;
      mem_write_o <= d_mem_write;
      mem_size_o  <= d_mem_size;
      illegal_o   <= d_illegal;
      if (instr_cnt_o != '1) instr_cnt_o <= instr_cnt_o + CNT_W'(1);
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: table vectors, hand-written stall/flush/reset sequences and
// random traffic checked against a transaction-level model, on an RV64 and an RV32 instance.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] instr = '0;
  logic [63:0] pc = '0;

  logic        in_ready, out_valid, alu_src, reg_write, word_op, mem_read, mem_write, illegal;
  logic [63:0] pc_o, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  mem_size;
  alu_op_t     alu_op;
  logic [31:0] cnt;

  logic        in_ready32, out_valid32, alu_src32, reg_write32, word_op32;
  logic        mem_read32, mem_write32, illegal32;
  logic [31:0] pc_o32, imm32;
  logic [4:0]  rs1_32, rs2_32, rd_32;
  logic [2:0]  mem_size32;
  alu_op_t     alu_op32;
  logic [2:0]  cnt32;

  decode_stage #(.XLEN(64), .CNT_W(32)) u_dut64 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .instr_i(instr), .pc_i(pc), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .pc_o(pc_o), .rs1_addr_o(rs1), .rs2_addr_o(rs2), .rd_addr_o(rd), .alu_op_o(alu_op),
    .alu_src_o(alu_src), .reg_write_o(reg_write), .imm_o(imm), .word_op_o(word_op),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_size_o(mem_size),
    .illegal_o(illegal), .instr_cnt_o(cnt)
  );

  decode_stage #(.XLEN(32), .CNT_W(3)) u_dut32 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready32),
    .instr_i(instr), .pc_i(pc[31:0]), .out_valid_o(out_valid32), .out_ready_i(out_ready),
    .pc_o(pc_o32), .rs1_addr_o(rs1_32), .rs2_addr_o(rs2_32), .rd_addr_o(rd_32),
    .alu_op_o(alu_op32), .alu_src_o(alu_src32), .reg_write_o(reg_write32), .imm_o(imm32),
    .word_op_o(word_op32), .mem_read_o(mem_read32), .mem_write_o(mem_write32),
    .mem_size_o(mem_size32), .illegal_o(illegal32), .instr_cnt_o(cnt32)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Decoded bundle as the reference sees it.
  typedef struct packed {
    logic [3:0]  alu_op;
    logic        alu_src, reg_write, mem_read, mem_write, word_op, illegal;
    logic [63:0] imm;
    logic [2:0]  mem_size;
    logic [4:0]  rs1, rs2, rd;
  } bundle_t;

  function automatic bundle_t ref_decode(input logic [31:0] ins, input int xlen);
    bundle_t b;
    alu_op_t base [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    int      f3 = int'(ins[14:12]);
    int      f7 = int'(ins[31:25]);
    bit      alt = ins[30];
    bit      rv64 = (xlen == 64);
    int      shift_hi = int'(ins[31:20]) / xlen;   // immediate bits above shamt
    bit      r_f7_ok = (f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5));
    longint  imm_i, imm_s, imm_u;
    imm_i = $signed(ins[31:20]);
    imm_s = $signed({ins[31:25], ins[11:7]});
    imm_u = $signed({ins[31:12], 12'h000});
    b = '0;
    b.rs1 = ins[19:15];
    b.rs2 = ins[24:20];
    b.rd  = ins[11:7];
    case (ins[6:0])
      7'h13: begin
        b.alu_src = 1; b.reg_write = 1; b.imm = imm_i; b.alu_op = base[f3];
        if (f3 == 1) b.illegal = (shift_hi != 0);
        if (f3 == 5) begin
          b.illegal = !(shift_hi == 0 || shift_hi == 'h400 / xlen);
          if (alt) b.alu_op = ALU_SRA;
        end
      end
      7'h33: begin
        b.reg_write = 1; b.alu_op = base[f3]; b.illegal = !r_f7_ok;
        if (alt && f3 == 0) b.alu_op = ALU_SUB;
        if (alt && f3 == 5) b.alu_op = ALU_SRA;
      end
      7'h03: begin
        b.mem_read = 1; b.reg_write = 1; b.alu_src = 1; b.imm = imm_i; b.mem_size = f3[2:0];
        b.illegal = (f3 == 7) || (!rv64 && (f3 == 3 || f3 == 6));
      end
      7'h23: begin
        b.mem_write = 1; b.alu_src = 1; b.imm = imm_s; b.mem_size = f3[2:0];
        b.illegal = (f3 >= 4) || (!rv64 && f3 == 3);
      end
      7'h37: begin
        b.reg_write = 1; b.alu_src = 1; b.imm = imm_u; b.rs1 = 0;
      end
      7'h1B: begin
        if (!rv64) b.illegal = 1;
        else begin
          b.word_op = 1; b.reg_write = 1; b.alu_src = 1; b.imm = imm_i;
          if (f3 == 1) begin b.alu_op = ALU_SLL; b.illegal = (f7 != 0); end
          else if (f3 == 5) begin
            b.alu_op = alt ? ALU_SRA : ALU_SRL;
            b.illegal = !(f7 == 0 || f7 == 'h20);
          end else if (f3 != 0) b.illegal = 1;
        end
      end
      7'h3B: begin
        if (!rv64) b.illegal = 1;
        else begin
          b.word_op = 1; b.reg_write = 1; b.illegal = !r_f7_ok;
          if (f3 == 0) b.alu_op = alt ? ALU_SUB : ALU_ADD;
          else if (f3 == 1) b.alu_op = ALU_SLL;
          else if (f3 == 5) b.alu_op = alt ? ALU_SRA : ALU_SRL;
          else b.illegal = 1;
        end
      end
      default: b.illegal = 1;
    endcase
    if (b.illegal) begin b.reg_write = 0; b.mem_read = 0; b.mem_write = 0; end
    if (b.rd == 0) b.reg_write = 0;
    return b;
  endfunction

  // Transaction-level model of what each instance should be presenting.
  bit          m_valid = 0;
  bundle_t     m64 = '0, m32 = '0;
  logic [63:0] m_pc = '0;
  longint      m_cnt64 = 0;
  int          m_cnt32 = 0;
  logic        last_ready;

  function automatic logic [63:0] ctl_of(input bundle_t b);
    return {b.alu_op, b.alu_src, b.reg_write, b.mem_read, b.mem_write, b.word_op, b.illegal,
            b.mem_size};
  endfunction

  task automatic cmp_all();
    check("out_valid", out_valid, m_valid);
    check("out_valid32", out_valid32, m_valid);
    check("pc", pc_o, m_pc);
    check("pc32", pc_o32, m_pc[31:0]);
    check("regs", {rs1, rs2, rd}, {m64.rs1, m64.rs2, m64.rd});
    check("regs32", {rs1_32, rs2_32, rd_32}, {m32.rs1, m32.rs2, m32.rd});
    check("ctl", {alu_op, alu_src, reg_write, mem_read, mem_write, word_op, illegal, mem_size},
          ctl_of(m64));
    check("ctl32", {alu_op32, alu_src32, reg_write32, mem_read32, mem_write32, word_op32,
                    illegal32, mem_size32}, ctl_of(m32));
    check("imm", imm, m64.imm);
    check("imm32", imm32, m32.imm[31:0]);
    check("cnt", cnt, m_cnt64);
    check("cnt32", cnt32, m_cnt32);
  endtask

  // One clock: drive, check the combinational ready, advance the model, compare everything.
  task automatic cycle(input bit r, input bit f, input bit v, input bit rdy,
                       input logic [31:0] ins, input logic [63:0] p);
    bit exp_ready, acc;
    rst = r; flush = f; in_valid = v; out_ready = rdy; instr = ins; pc = p;
    #1;
    exp_ready  = !r && (!m_valid || rdy);
    acc        = v && exp_ready;
    last_ready = in_ready;
    check("in_ready", in_ready, exp_ready);
    check("in_ready32", in_ready32, exp_ready);
    @(posedge clk);
    if (r) begin
      m_valid = 0; m64 = '0; m32 = '0; m_pc = '0; m_cnt64 = 0; m_cnt32 = 0;
    end else if (f) begin
      m_valid = 0;
    end else if (acc) begin
      m_valid = 1;
      m64 = ref_decode(ins, 64);
      m32 = ref_decode(ins, 32);
      m_pc = p;
      if (m_cnt64 < 64'hFFFF_FFFF) m_cnt64++;
      if (m_cnt32 < 7) m_cnt32++;
    end else if (rdy) begin
      m_valid = 0;
    end
    #1;
    cmp_all();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [10] = '{7'h03, 7'h13, 7'h1B, 7'h23, 7'h33, 7'h37, 7'h3B, 7'h6F, 7'h63, 7'h13};
    logic [31:0] r = $urandom;
    r[6:0] = ops[$urandom_range(9)];
    case ($urandom_range(3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      default: ;
    endcase
    if ($urandom_range(7) == 0) r[11:7] = 5'd0;
    return r;
  endfunction

  typedef struct packed {
    logic [31:0] instr;
    logic [3:0]  alu_op;
    logic [5:0]  ctl;      // {alu_src, reg_write, mem_read, mem_write, word_op, illegal}
    logic [63:0] imm;
    logic [2:0]  mem_size;
    logic [4:0]  rs1;
    logic        ill32;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  initial begin
    vecs[0]  = '{32'hFFF00093, ALU_ADD, 6'b110000, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 5'd0, 1'b0};
    vecs[1]  = '{32'h0020A423, ALU_ADD, 6'b100100, 64'd8,                   3'd2, 5'd1, 1'b0};
    vecs[2]  = '{32'h402081BB, ALU_SUB, 6'b010010, 64'd0,                   3'd0, 5'd1, 1'b1};
    vecs[3]  = '{32'h800002B7, ALU_ADD, 6'b110000, 64'hFFFF_FFFF_8000_0000, 3'd0, 5'd0, 1'b0};
    vecs[4]  = '{32'h0000006F, ALU_ADD, 6'b000001, 64'd0,                   3'd0, 5'd0, 1'b1};
    vecs[5]  = '{32'h00208033, ALU_ADD, 6'b000000, 64'd0,                   3'd0, 5'd1, 1'b0};
    vecs[6]  = '{32'h0000B083, ALU_ADD, 6'b111000, 64'd0,                   3'd3, 5'd1, 1'b1};
    vecs[7]  = '{32'h43F0D093, ALU_SRA, 6'b110000, 64'h43F,                 3'd0, 5'd1, 1'b1};
    vecs[8]  = '{32'h40009093, ALU_SLL, 6'b100001, 64'h400,                 3'd0, 5'd1, 1'b1};
    vecs[9]  = '{32'h4020C0B3, ALU_XOR, 6'b000001, 64'd0,                   3'd0, 5'd1, 1'b1};
    vecs[10] = '{32'h0000F083, ALU_ADD, 6'b100001, 64'd0,                   3'd7, 5'd1, 1'b1};
    vecs[11] = '{32'h0020B023, ALU_ADD, 6'b100100, 64'd0,                   3'd3, 5'd1, 1'b1};
    vecs[12] = '{32'hFFE0809B, ALU_ADD, 6'b110010, 64'hFFFF_FFFF_FFFF_FFFE, 3'd0, 5'd1, 1'b1};
    vecs[13] = '{32'h0020C023, ALU_ADD, 6'b100001, 64'd0,                   3'd4, 5'd1, 1'b1};

    // Reset state.
    cycle(1, 0, 1, 1, 32'hFFF00093, 64'h0);
    cycle(1, 0, 0, 1, 32'h0, 64'h0);
    check("rst_ready", last_ready, 0);
    check("rst_valid", out_valid, 0);
    check("rst_cnt", cnt, 0);
    check("rst_alu_op", alu_op, ALU_ADD);

    // Back-to-back table vectors at full throughput.
    for (int i = 0; i < NV; i++) begin
      cycle(0, 0, 1, 1, vecs[i].instr, 64'h1000 + 64'(4 * i));
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      check($sformatf("vec%0d_alu_op", i), alu_op, vecs[i].alu_op);
      check($sformatf("vec%0d_ctl", i),
            {alu_src, reg_write, mem_read, mem_write, word_op, illegal}, vecs[i].ctl);
      check($sformatf("vec%0d_imm", i), imm, vecs[i].imm);
      check($sformatf("vec%0d_mem_size", i), mem_size, vecs[i].mem_size);
      check($sformatf("vec%0d_rs1", i), rs1, vecs[i].rs1);
      check($sformatf("vec%0d_ill32", i), illegal32, vecs[i].ill32);
      check($sformatf("vec%0d_cnt", i), cnt, i + 1);
      check($sformatf("vec%0d_cnt32_sat", i), cnt32, (i + 1 > 7) ? 7 : i + 1);
    end

    // Backpressure: three stalled cycles, then release accepts the waiting instruction.
    cycle(0, 0, 1, 1, 32'hFFF00093, 64'h2000);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 1, 0, 32'h800002B7, 64'h2004);
      check("stall_ready", last_ready, 0);
      check("stall_valid", out_valid, 1);
      check("stall_imm", imm, 64'hFFFF_FFFF_FFFF_FFFF);
      check("stall_pc", pc_o, 64'h2000);
      check("stall_cnt", cnt, NV + 1);
    end
    cycle(0, 0, 1, 1, 32'h800002B7, 64'h2004);
    check("release_ready", last_ready, 1);
    check("release_imm", imm, 64'hFFFF_FFFF_8000_0000);
    check("release_pc", pc_o, 64'h2004);
    check("release_cnt", cnt, NV + 2);

    // Flush on an accepting cycle drops the instruction and does not count it.
    cycle(0, 1, 1, 1, 32'h0020A423, 64'h2008);
    check("flush_ready", last_ready, 1);
    check("flush_valid", out_valid, 0);
    check("flush_cnt", cnt, NV + 2);

    // Reset while stalled discards the held bundle.
    cycle(0, 0, 1, 1, 32'h0020A423, 64'h200C);
    cycle(0, 0, 1, 0, 32'h00208033, 64'h2010);
    cycle(1, 0, 1, 0, 32'h00208033, 64'h2010);
    check("rst_stall_valid", out_valid, 0);
    check("rst_stall_imm", imm, 0);
    check("rst_stall_pc", pc_o, 0);
    check("rst_stall_mem_write", mem_write, 0);
    check("rst_stall_cnt", cnt, 0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bit r, f, v, rdy;
      r   = ($urandom_range(63) == 0);
      f   = ($urandom_range(11) == 0);
      v   = ($urandom_range(3) != 0);
      rdy = ($urandom_range(9) < 7);
      cycle(r, f, v, rdy, rand_instr(), {$urandom, $urandom});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered, handshaked instruction-decode pipeline stage for the RV64 core. It sits between fetch and execute. It accepts one instruction per cycle under valid/ready flow control and produces a registered control bundle. Compared with the purely combinational decoder, it adds:
- LOAD, STORE, LUI and RV64 word-op (OP_IMM_32/OP_32) decoding
- illegal-instruction detection
- pipeline flush
- a saturating count of decoded instructions

Parameters:
XLEN, 64, datapath width; legal values 32 or 64. When XLEN=32, word ops, LD, LWU and SD are illegal.
CNT_W, 32, width of the decoded-instruction counter.

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_i  in  1  synchronous, active-high reset
flush_i  in  1  discard the held/outgoing instruction
in_valid_i  in  1  fetch presents an instruction
in_ready_o  out  1  stage can accept
instr_i  in  32  raw instruction
pc_i  in  XLEN  instruction PC
out_valid_o  out  1  registered bundle valid
out_ready_i  in  1  execute accepts the bundle
pc_o  out  XLEN  registered PC
rs1_addr_o  out  5  source register 1
rs2_addr_o  out  5  source register 2
rd_addr_o  out  5  destination register
alu_op_o  out  alu_op_t  ALU operation
alu_src_o  out  1  0 = rs2, 1 = immediate
reg_write_o  out  1  write rd
imm_o  out  XLEN  sign-extended immediate
word_op_o  out  1  32-bit op; execute sign-extends result[31:0]
mem_read_o  out  1  load
mem_write_o  out  1  store
mem_size_o  out  3  funct3 of the load/store
illegal_o  out  1  unsupported or illegal encoding
instr_cnt_o  out  CNT_W  count of accepted instructions

Behaviour:
- Handshake:
  - in_ready_o = !rst_i && (!out_valid_o || out_ready_i), combinational.
  - Accept occurs when in_valid_i && in_ready_o. All output registers load on the next edge and out_valid_o rises, giving 1-cycle latency.
  - Full throughput: back-to-back accepts are allowed while out_ready_i=1.
  - While out_valid_o && !out_ready_i, every output is held bit-stable.
  - Outputs not accepted and not replaced also hold stable. A consumed bundle with no new accept clears out_valid_o only; data fields hold.
- Flush:
  - On a flush_i edge, out_valid_o becomes 0 and any simultaneous accept is dropped (flush wins).
  - in_ready_o is unaffected by flush_i in the same cycle.
  - instr_cnt_o does not increment on a flush-dropped accept.
- Reset: every output register clears to 0 (alu_op_o = ALU_ADD). out_valid_o=0, instr_cnt_o=0, in_ready_o=0 while rst_i=1. Reset mid-stall discards the held bundle.
- Counter: instr_cnt_o increments by 1 per non-flushed accept and saturates at all-ones. It is cleared only by rst_i.
- Decode defaults: reg_write, mem_read, mem_write, word_op, alu_src, illegal all 0; alu_op=ALU_ADD; imm=0. Register fields are taken from fixed bit positions.
- Immediates:
  - I-type sext(instr[31:20]) for OP_IMM, LOAD, OP_IMM_32.
  - S-type sext({instr[31:25], instr[11:7]}) for STORE.
  - U-type sext({instr[31:12], 12'b0}) for LUI.
- OP_IMM / OP_REG: ALU mapping as the existing decoder.
  - Shift-immediate: shamt width is log2(XLEN). The upper funct7 bits must be 0, or 0100000 for SRAI; otherwise illegal.
  - OP_REG: funct7 must be 0000000, or 0100000 with funct3 in {000, 101}; otherwise illegal.
- LOAD: mem_read=1, reg_write=1, alu_src=1, ADD.
  - funct3 111 is illegal.
  - 011 and 110 are illegal when XLEN=32.
- STORE: mem_write=1, alu_src=1, ADD.
  - funct3 >= 100 is illegal.
  - 011 is illegal when XLEN=32.
- LUI: reg_write=1, alu_src=1, ADD, rs1_addr_o forced to 0.
- OP_IMM_32 (XLEN=64 only): word_op=1.
  - Legal: ADDIW (000); SLLIW (001, funct7=0); SRLIW/SRAIW (101, funct7 0000000/0100000). Anything else is illegal.
- OP_32 (XLEN=64 only): word_op=1.
  - Legal: ADDW/SUBW (000), SLLW (001), SRLW/SRAW (101). funct7 rules are as OP_REG.
- Any other opcode is illegal.
- Illegal instructions: illegal_o=1 and reg_write/mem_read/mem_write forced to 0. The bundle still flows with out_valid_o=1 and is counted.
- rd=x0: reg_write_o is forced to 0. mem_read_o is unaffected.

Test Plan:
1. ADDI x1,x0,-1 (0xFFF00093), out_ready_i=1 → next cycle:
   - out_valid_o=1, imm_o=0xFFFFFFFFFFFFFFFF
   - alu_op_o=ALU_ADD, alu_src_o=1, reg_write_o=1, rd_addr_o=1
   - instr_cnt_o=1
2. SW x2,8(x1) (0x0020A423) → imm_o=8, mem_write_o=1, reg_write_o=0, mem_size_o=3'b010, rs1=1, rs2=2.
3. SUBW x3,x1,x2 (0x402081BB) → ALU_SUB, word_op_o=1, reg_write_o=1. LUI x5,0x80000 (0x800002B7) → imm_o=0xFFFFFFFF80000000, rs1_addr_o=0.
4. Backpressure: out_ready_i=0 for 3 cycles with in_valid_i=1 →
   - in_ready_o=0 and outputs stable every cycle
   - on release, the next instruction is accepted the same cycle
   - instr_cnt_o counts exactly the accepted instructions
5. flush_i asserted on the same cycle as an accept → out_valid_o=0 next cycle and instr_cnt_o unchanged. rst_i during a stall → all outputs 0 next cycle.
6. JAL (0x0000006F) → illegal_o=1, reg_write_o=0. ADD x0,x1,x2 (0x00208033) → reg_write_o=0. With XLEN=32, LD (0x0000B083) → illegal_o=1.
